// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the
// nibble-serial ripple-carry add/sub unit.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rca_seq_addsub_nibble.sv
// addsub_nibble: 4-bit gate-level full-adder chain with b inversion for subtract.
// Ports: a, b (4b), cin, op in; s (4b), cout, c_msb_in (carry into bit 3) out.
module addsub_nibble
  import rca_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  input  logic                op,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c_msb_in
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W:0]   cy;

  assign bx    = b ^ {NIBBLE_W{op}};
  assign cy[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    logic p;
    assign p       = a[i] ^ bx[i];
    assign s[i]    = p ^ cy[i];
    assign cy[i+1] = (a[i] & bx[i]) | (cy[i] & p);
  end

  assign cout     = cy[NIBBLE_W];
  assign c_msb_in = cy[NIBBLE_W-1];

endmodule

// File: rtl/rca_seq.sv
// rca_seq: sequential add/sub, one 4-bit slice per cycle, valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready, a, b, op, out_valid/out_ready, s, c, v, z, busy.
module rca_seq
  import rca_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   c,
  output logic                   v,
  output logic                   z,
  output logic                   busy
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  state_t              state;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                op_q;
  logic [IW-1:0]       idx;
  logic                carry;

  logic [NIBBLE_W-1:0] sl_a;
  logic [NIBBLE_W-1:0] sl_b;
  logic [NIBBLE_W-1:0] sl_s;
  logic                sl_cout;
  logic                sl_c3;
  logic [W-1:0]        s_nx;
  logic                last;

  assign sl_a = a_q[{idx, 2'b00} +: NIBBLE_W];
  assign sl_b = b_q[{idx, 2'b00} +: NIBBLE_W];
  assign last = (idx == IW'(NIBBLES - 1));

  addsub_nibble u_nib (
    .a        (sl_a),
    .b        (sl_b),
    .cin      (carry),
    .op       (op_q),
    .s        (sl_s),
    .cout     (sl_cout),
    .c_msb_in (sl_c3)
  );

  // Full word with the current slice merged in; z needs the whole result
  // on the final slice before s itself is updated.
  always_comb begin
    s_nx = s;
    s_nx[{idx, 2'b00} +: NIBBLE_W] = sl_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      s     <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
      z     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            idx   <= '0;
            carry <= op;
            state <= RUN;
          end
        end
        RUN: begin
          s     <= s_nx;
          carry <= sl_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            c     <= sl_cout ^ op_q;
            v     <= sl_c3 ^ sl_cout;
            z     <= (s_nx == '0);
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rca_seq.sv
// Self-checking bench for rca_seq (NIBBLES = 4): directed table,
// corner sequences and a randomized scoreboard against an arithmetic model.
module tb_rca_seq;

  localparam int N = 4;
  localparam int W = 4 * N;
  localparam int NRAND = 10000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] s;
  logic         c;
  logic         v;
  logic         z;
  logic         busy;

  int errors = 0;
  int checks = 0;

  rca_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c         (c),
    .v         (v),
    .z         (z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain W-bit arithmetic; returns {s, c, v, z}.
  function automatic logic [W+2:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic o);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         cc, vv;
    if (!o) begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[W-1:0];
      cc   = full[W];
      vv   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r    = x - y;
      cc   = (x < y);
      vv   = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {r, cc, vv, (r == '0)};
  endfunction

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic o);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    op = o;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input logic [W+2:0] e);
    chk({tag, "_s"}, 32'(s), 32'(e[W+2:3]));
    chk({tag, "_c"}, 32'(c), 32'(e[2]));
    chk({tag, "_v"}, 32'(v), 32'(e[1]));
    chk({tag, "_z"}, 32'(z), 32'(e[0]));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t         vecs[8];
    int           lat;
    int           hi;
    logic [W+2:0] held;
    logic [W+2:0] exp_q[$];
    logic [W+2:0] e;
    int           sent;
    int           done;
    int           cyc;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset");
    check_res("reset", '0);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
      check_res($sformatf("vec%0d", i),
                {vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drop", i), 32'(out_valid), 32'd0);
    end

    // Backpressure in DONE with a competing request
    start(16'h7FFF, 16'h0001, 1'b0);
    wait_out(lat);
    held = model(16'h7FFF, 16'h0001, 1'b0);
    a = 16'h1111;
    b = 16'h2222;
    op = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      check_res($sformatf("bp%0d", k), held);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("bp_after");

    // out_ready already high when DONE is entered
    out_ready = 1'b1;
    start(16'h0001, 16'h0002, 1'b1);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        hi++;
        check_res("ordy_early", model(16'h0001, 16'h0002, 1'b1));
      end
      tick();
    end
    out_ready = 1'b0;
    chk("ordy_early_pulse", 32'(hi), 32'd1);

    // Reset on RUN cycle 2
    start(16'hABCD, 16'h1357, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    check_res("midrst", '0);
    start(16'h4321, 16'h1234, 1'b1);
    wait_out(lat);
    chk("postrst_latency", 32'(lat), 32'(N));
    check_res("postrst", model(16'h4321, 16'h1234, 1'b1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized scoreboard
    sent = 0;
    done = 0;
    cyc = 0;
    while (done < NRAND && cyc < 90000) begin
      out_ready = ($urandom_range(15) != 0);
      in_valid  = (sent < NRAND) && ($urandom_range(15) != 0);
      a  = W'($urandom);
      b  = W'($urandom);
      op = 1'($urandom);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({s, c, v, z} !== e) begin
            errors++;
            $display("FAIL rand%0d: got s=%0h c=%0b v=%0b z=%0b, expected s=%0h c=%0b v=%0b z=%0b",
                     done, s, c, v, z, e[W+2:3], e[2], e[1], e[0]);
          end
        end
        done++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, op));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_completed", 32'(done), 32'(NRAND));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
